// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory port arbiter: FSM state encoding,
// granted-port select values and default parameter values.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   // Granted-port register encoding.
   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_LS = 1'b1;

   // Default parameter values.
   localparam int DEF_ADDR_W     = 16;
   localparam int DEF_DATA_W     = 128;
   localparam int DEF_RD_LAT     = 2;
   localparam int DEF_STREAK_MAX = 4;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, the load/store port and the memory-side bus of the
// memory port arbiter.
//   slave  : the arbiter's view (requests and mem_rdata in; grants, rvalids,
//            rdata, memory address/data/strobes and busy out)
//   master : the environment's view (requesters plus external memory)
//
// Handshake: a requester raises req with address/data and keeps all of them
// stable until the cycle in which its gnt pulses. gnt is a one-cycle pulse
// marking the issue of that request to memory. Holding req high in the cycle
// after gnt presents a new request. Read data arrives later with a one-cycle
// rvalid pulse; rdata is shared and only meaningful while rvalid is high.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   // fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;

   // load/store port
   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_gnt;
   logic              ls_rvalid;

   // shared read data
   logic [DATA_W-1:0] rdata;

   // memory side
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mw_en;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      output if_gnt, if_rvalid, ls_gnt, ls_rvalid, rdata,
             mem_addr, mem_wdata, mw_en, mem_re, busy
   );

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      input  if_gnt, if_rvalid, ls_gnt, ls_rvalid, rdata,
             mem_addr, mem_wdata, mw_en, mem_re, busy
   );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch and load/store. One
// transaction is outstanding at a time. Load/store wins by default; a streak
// counter forces a fetch grant after STREAK_MAX load/store grants made while
// fetch was waiting.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   bus          mem_port_arbiter_if.slave (requesters + memory bus)
//   dbg_state_o  current FSM state
//
// Parameters: ADDR_W, DATA_W, RD_LAT (1..7), STREAK_MAX (1..15).
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int RD_LAT     = DEF_RD_LAT,
   parameter int STREAK_MAX = DEF_STREAK_MAX
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_port_arbiter_if.slave    bus,
   output arb_state_e           dbg_state_o
);

   localparam logic [2:0] RD_LAT_C     = 3'(RD_LAT);
   localparam logic [3:0] STREAK_MAX_C = 4'(STREAK_MAX);

   arb_state_e        state_q, state_d;
   logic              port_q, port_d;
   logic              we_q, we_d;
   logic [3:0]        streak_q, streak_d;
   logic [2:0]        wcnt_q, wcnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic arb_point;
   logic grant;
   logic pick_if;

   // Decisions are only taken at the edge ending an IDLE or RESP cycle;
   // requests seen during ISSUE/WAIT simply stay pending.
   assign arb_point = (state_q == ST_IDLE) || (state_q == ST_RESP);
   assign grant     = arb_point && (bus.if_req || bus.ls_req);
   // Fetch wins when alone, or when load/store has used up its streak.
   assign pick_if   = bus.if_req && (!bus.ls_req || (streak_q == STREAK_MAX_C));

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         port_q      <= PORT_IF;
         we_q        <= 1'b0;
         streak_q    <= 4'd0;
         wcnt_q      <= 3'd0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         port_q      <= port_d;
         we_q        <= we_d;
         streak_q    <= streak_d;
         wcnt_q      <= wcnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d     = state_q;
      port_d      = port_q;
      we_d        = we_q;
      streak_d    = streak_q;
      wcnt_d      = wcnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;

      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (grant) state_d = ST_ISSUE;
            else       state_d = ST_IDLE;
         end
         ST_ISSUE: begin
            if (we_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
               wcnt_d  = RD_LAT_C;
            end
         end
         ST_WAIT: begin
            wcnt_d = wcnt_q - 3'd1;
            // Last WAIT cycle: memory data is valid now.
            if (wcnt_q == 3'd1) begin
               state_d = ST_RESP;
               rdata_d = bus.mem_rdata;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (grant) begin
         port_d     = pick_if ? PORT_IF : PORT_LS;
         // Fetch is read-only, so only a load/store grant can become a write.
         we_d       = !pick_if && bus.ls_we;
         mem_addr_d = pick_if ? bus.if_addr : bus.ls_addr;
         if (!pick_if && bus.ls_we) mem_wdata_d = bus.ls_wdata;
         // The streak only grows while fetch is actually being held off.
         if (pick_if || !bus.if_req) streak_d = 4'd0;
         else                        streak_d = streak_q + 4'd1;
      end
   end

   // ---------------- output logic ----------------
   always_comb begin
      bus.if_gnt    = (state_q == ST_ISSUE) && (port_q == PORT_IF);
      bus.ls_gnt    = (state_q == ST_ISSUE) && (port_q == PORT_LS);
      bus.mw_en     = (state_q == ST_ISSUE) && we_q;
      bus.mem_re    = (state_q == ST_ISSUE) && !we_q;
      bus.if_rvalid = (state_q == ST_RESP) && (port_q == PORT_IF);
      bus.ls_rvalid = (state_q == ST_RESP) && (port_q == PORT_LS);
      bus.busy      = (state_q != ST_IDLE);
      bus.mem_addr  = mem_addr_q;
      bus.mem_wdata = mem_wdata_q;
      bus.rdata     = rdata_q;
      dbg_state_o   = state_q;
   end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. Main instance uses RD_LAT=2,
// STREAK_MAX=4; a second instance with RD_LAT=1 covers back-to-back fetch.
// Events (grants, read returns, stray strobes) are recorded by a monitor and
// compared with a transaction-level model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW  = 16;
   localparam int DW  = 128;
   localparam int RD  = 2;
   localparam int SM  = 4;
   localparam int RD1 = 1;
   localparam int EW  = 165;  // {cycle[15:0], kind[1:0], port, mw_en, mem_re, addr[15:0], data[127:0]}

   localparam logic [DW-1:0] LOAD_DATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
   localparam logic [DW-1:0] WD1       = 128'h1234_5678_9ABC_DEF0_1122_3344_5566_7788;
   localparam logic [DW-1:0] WD2       = 128'h8765_4321_0FED_CBA9_8877_6655_4433_2211;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
   arb_state_e dbg_state, dbg_state1;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD), .STREAK_MAX(SM)) dut (
      .clk(clk), .reset(reset), .bus(bus), .dbg_state_o(dbg_state)
   );

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD1), .STREAK_MAX(SM)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1), .dbg_state_o(dbg_state1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- memory model + monitor ----------------
   logic [DW-1:0] mem [logic [AW-1:0]];
   logic [EW-1:0] act_q[$];
   logic [EW-1:0] exp_q[$];
   int            rd_cd = 0;
   logic [AW-1:0] rd_addr = '0;

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return {8{a ^ 16'hA5C3}};
   endfunction

   function automatic logic [EW-1:0] mk_ev(input int c, input logic [1:0] k, input logic p,
                                           input logic w, input logic r,
                                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic [15:0] cc;
      cc = c[15:0];
      return {cc, k, p, w, r, a, d};
   endfunction

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      return mem.exists(a) ? mem[a] : pat(a);
   endfunction

   always @(posedge clk) begin
      #1;
      // Memory: data valid RD cycles after mem_re, junk otherwise.
      if (rd_cd > 0) begin
         rd_cd--;
         bus.mem_rdata = (rd_cd == 0) ? mem_rd(rd_addr) : {4{$urandom}};
      end
      if (bus.mem_re) begin
         rd_cd   = RD;
         rd_addr = bus.mem_addr;
      end
      if (bus.mw_en) mem[bus.mem_addr] = bus.mem_wdata;
      // Event capture.
      if (bus.if_gnt && bus.ls_gnt)
         act_q.push_back(mk_ev(cyc, 2'd2, 1'b1, bus.mw_en, bus.mem_re, bus.mem_addr, '0));
      else if (bus.if_gnt || bus.ls_gnt)
         act_q.push_back(mk_ev(cyc, 2'd0, bus.ls_gnt, bus.mw_en, bus.mem_re, bus.mem_addr,
                               bus.mw_en ? bus.mem_wdata : '0));
      else if (bus.mw_en || bus.mem_re)
         act_q.push_back(mk_ev(cyc, 2'd2, 1'b0, bus.mw_en, bus.mem_re, bus.mem_addr, '0));
      if (bus.if_rvalid && bus.ls_rvalid)
         act_q.push_back(mk_ev(cyc, 2'd2, 1'b1, 1'b0, 1'b0, '0, bus.rdata));
      else if (bus.if_rvalid || bus.ls_rvalid)
         act_q.push_back(mk_ev(cyc, 2'd1, bus.ls_rvalid, 1'b0, 1'b0, '0, bus.rdata));
   end

   // ---------------- driver tasks ----------------
   logic [AW-1:0]    if_drv[$];
   logic [AW+DW:0]   ls_drv[$];   // {we, addr, wdata}

   task automatic drive_heads();
      bus.if_req  = (if_drv.size() > 0);
      bus.if_addr = (if_drv.size() > 0) ? if_drv[0] : '0;
      if (ls_drv.size() > 0) begin
         bus.ls_req = 1'b1;
         {bus.ls_we, bus.ls_addr, bus.ls_wdata} = ls_drv[0];
      end else begin
         bus.ls_req = 1'b0;
      end
   endtask

   task automatic apply_reset();
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      reset      = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      act_q.delete();
   endtask

   // Requests are driven in cycle c0, so the first issue lands in c0+1.
   task automatic run_traffic(output int c0, input int budget);
      int n;
      @(posedge clk);
      #2;
      c0 = cyc;
      drive_heads();
      n = 0;
      while ((if_drv.size() > 0 || ls_drv.size() > 0) && n < budget) begin
         @(posedge clk);
         #2;
         n++;
         if (bus.if_gnt && if_drv.size() > 0) void'(if_drv.pop_front());
         if (bus.ls_gnt && ls_drv.size() > 0) void'(ls_drv.pop_front());
         drive_heads();
      end
      n_checks++;
      if (if_drv.size() > 0 || ls_drv.size() > 0) begin
         n_fail++;
         $display("FAIL traffic_timeout: pending if=%0d ls=%0d after %0d cycles, required 0",
                  if_drv.size(), ls_drv.size(), budget);
         if_drv.delete();
         ls_drv.delete();
         drive_heads();
      end
      repeat (RD + 3) @(posedge clk);
      #2;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bus.if_req  = 1'b1;  bus.if_addr = 16'h0050;
      bus.ls_req  = 1'b1;  bus.ls_we   = 1'b0;  bus.ls_addr = 16'h0040;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #2;
         n_checks++;
         if ({bus.if_gnt, bus.if_rvalid, bus.ls_gnt, bus.ls_rvalid, bus.mw_en, bus.mem_re,
              bus.busy} !== 7'b0 || bus.rdata !== '0 || bus.mem_addr !== '0 ||
             bus.mem_wdata !== '0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_outputs: cycle %0d strobes=%b addr=%h state=%0d, required all 0",
                     i, {bus.if_gnt, bus.if_rvalid, bus.ls_gnt, bus.ls_rvalid, bus.mw_en,
                         bus.mem_re, bus.busy}, bus.mem_addr, dbg_state);
         end
      end
      reset = 1'b0;
      @(posedge clk);
      #2;
      n_checks++;
      if ({bus.ls_gnt, bus.if_gnt, bus.mem_re} !== 3'b101 || bus.mem_addr !== 16'h0040) begin
         n_fail++;
         $display("FAIL reset_first_grant: ls_gnt/if_gnt/mem_re=%b addr=%h, required 101 addr 0040",
                  {bus.ls_gnt, bus.if_gnt, bus.mem_re}, bus.mem_addr);
      end
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      repeat (RD + 3) @(posedge clk);
   endtask

   task automatic test_load_read();
      int c0;
      apply_reset();
      mem[16'h0010] = LOAD_DATA;
      ls_drv.push_back({1'b0, 16'h0010, 128'h0});
      run_traffic(c0, 20);
      n_checks++;
      if (act_q.size() != 2) begin
         n_fail++;
         $display("FAIL load_event_count: got %0d, required 2", act_q.size());
      end
      n_checks++;
      if (act_q[0] !== mk_ev(c0 + 1, 2'd0, 1'b1, 1'b0, 1'b1, 16'h0010, '0)) begin
         n_fail++;
         $display("FAIL load_grant: got %h, required %h", act_q[0],
                  mk_ev(c0 + 1, 2'd0, 1'b1, 1'b0, 1'b1, 16'h0010, '0));
      end
      n_checks++;
      if (act_q[1] !== mk_ev(c0 + 4, 2'd1, 1'b1, 1'b0, 1'b0, '0, LOAD_DATA)) begin
         n_fail++;
         $display("FAIL load_rvalid: got %h, required %h", act_q[1],
                  mk_ev(c0 + 4, 2'd1, 1'b1, 1'b0, 1'b0, '0, LOAD_DATA));
      end
   endtask

   task automatic test_store();
      int c0;
      apply_reset();
      ls_drv.push_back({1'b1, 16'h0200, WD1});
      ls_drv.push_back({1'b1, 16'h0204, WD2});
      run_traffic(c0, 20);
      n_checks++;
      if (act_q.size() != 2) begin
         n_fail++;
         $display("FAIL store_event_count: got %0d, required 2", act_q.size());
      end
      n_checks++;
      if (act_q[0] !== mk_ev(c0 + 1, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0200, WD1)) begin
         n_fail++;
         $display("FAIL store_first: got %h, required %h", act_q[0],
                  mk_ev(c0 + 1, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0200, WD1));
      end
      n_checks++;
      if (act_q[1] !== mk_ev(c0 + 3, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0204, WD2)) begin
         n_fail++;
         $display("FAIL store_second: got %h, required %h", act_q[1],
                  mk_ev(c0 + 3, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0204, WD2));
      end
   endtask

   task automatic test_fairness();
      int c0;
      int g;
      logic [9:0] order;
      order = 10'b1111011110;  // first grant in MSB; 1 = load/store, 0 = fetch
      apply_reset();
      if_drv.push_back(16'h0100);
      if_drv.push_back(16'h0101);
      for (int i = 0; i < 8; i++) ls_drv.push_back({1'b0, 16'(16'h0300 + i), 128'h0});
      run_traffic(c0, 200);
      g = 0;
      foreach (act_q[i]) begin
         if (act_q[i][148:147] == 2'd0 && g < 10) begin
            n_checks++;
            if (act_q[i][146] !== order[9-g] || act_q[i][164:149] !== 16'(c0 + 1 + g * (RD + 2))) begin
               n_fail++;
               $display("FAIL fair_grant%0d: port=%b cycle=%0d, required port=%b cycle=%0d", g,
                        act_q[i][146], act_q[i][164:149], order[9-g], c0 + 1 + g * (RD + 2));
            end
            g++;
         end
      end
      n_checks++;
      if (g != 10) begin
         n_fail++;
         $display("FAIL fair_grant_count: got %0d, required 10", g);
      end
   endtask

   task automatic test_reset_in_wait();
      int t;
      apply_reset();
      @(posedge clk);
      #2;
      bus.ls_req = 1'b1;  bus.ls_we = 1'b0;  bus.ls_addr = 16'h0010;
      bus.if_req = 1'b1;  bus.if_addr = 16'h0030;
      @(posedge clk);
      #2;
      t = cyc;
      bus.ls_req = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;            // sampled at the end of the first WAIT cycle
      @(posedge clk);
      #2;
      n_checks++;
      if ({bus.busy, bus.if_rvalid, bus.ls_rvalid, bus.mem_re, bus.if_gnt} !== 5'b0 ||
          bus.rdata !== '0 || bus.mem_addr !== '0) begin
         n_fail++;
         $display("FAIL abort_outputs: busy/rv/rv/re/gnt=%b addr=%h, required all 0",
                  {bus.busy, bus.if_rvalid, bus.ls_rvalid, bus.mem_re, bus.if_gnt}, bus.mem_addr);
      end
      reset = 1'b0;
      @(posedge clk);
      #2;
      n_checks++;
      if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 16'h0030) begin
         n_fail++;
         $display("FAIL abort_fetch_grant: if_gnt=%b addr=%h, required 1 addr 0030",
                  bus.if_gnt, bus.mem_addr);
      end
      bus.if_req = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      exp_q.delete();
      exp_q.push_back(mk_ev(t,     2'd0, 1'b1, 1'b0, 1'b1, 16'h0010, '0));
      exp_q.push_back(mk_ev(t + 3, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0030, '0));
      exp_q.push_back(mk_ev(t + 6, 2'd1, 1'b0, 1'b0, 1'b0, '0, pat(16'h0030)));
      n_checks++;
      if (act_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL abort_event_count: got %0d, required %0d", act_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (act_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL abort_event%0d: got %h, required %h", i, act_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int c0, ng, nr, cd;
      int gc[3];
      int rc[3];
      logic [AW-1:0] ga[3];
      logic [DW-1:0] rv[3];
      logic [AW-1:0] pa;
      ng = 0; nr = 0; cd = 0; pa = '0;
      @(posedge clk);
      #2;
      c0 = cyc;
      bus1.if_req  = 1'b1;
      bus1.if_addr = 16'h0000;
      for (int k = 0; k < 14; k++) begin
         @(posedge clk);
         #2;
         if (cd > 0) begin
            cd--;
            bus1.mem_rdata = (cd == 0) ? pat(pa) : {4{$urandom}};
         end
         if (bus1.mem_re) begin
            cd = RD1;
            pa = bus1.mem_addr;
         end
         if (bus1.if_gnt) begin
            if (ng < 3) begin
               gc[ng] = cyc;
               ga[ng] = bus1.mem_addr;
            end
            ng++;
            if (ng < 3) bus1.if_addr = 16'(ng);
            else        bus1.if_req  = 1'b0;
         end
         if (bus1.if_rvalid) begin
            if (nr < 3) begin
               rc[nr] = cyc;
               rv[nr] = bus1.rdata;
            end
            nr++;
         end
      end
      n_checks++;
      if (ng != 3 || nr != 3) begin
         n_fail++;
         $display("FAIL b2b_counts: gnt=%0d rvalid=%0d, required 3 and 3", ng, nr);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (gc[i] != c0 + 1 + 3 * i || ga[i] !== 16'(i)) begin
               n_fail++;
               $display("FAIL b2b_gnt%0d: cycle=%0d addr=%h, required cycle=%0d addr=%h",
                        i, gc[i], ga[i], c0 + 1 + 3 * i, 16'(i));
            end
            n_checks++;
            if (rc[i] != c0 + 3 + 3 * i || rv[i] !== pat(16'(i))) begin
               n_fail++;
               $display("FAIL b2b_rvalid%0d: cycle=%0d data=%h, required cycle=%0d data=%h",
                        i, rc[i], rv[i], c0 + 3 + 3 * i, pat(16'(i)));
            end
         end
      end
   endtask

   task automatic test_random(input int iter);
      int c0, t, streak;
      logic [AW-1:0]  base, a;
      logic [AW-1:0]  iq[$];
      logic [AW+DW:0] lq[$];
      logic [AW+DW:0] e;
      logic [DW-1:0]  mm [logic [AW-1:0]];
      base = 16'(16'h1000 * (iter + 1));
      apply_reset();
      for (int i = 0; i < $urandom_range(4, 12); i++)
         if_drv.push_back(base + 16'($urandom_range(0, 15)));
      for (int i = 0; i < $urandom_range(8, 24); i++)
         ls_drv.push_back({1'($urandom_range(0, 1)), base + 16'($urandom_range(0, 15)),
                           {4{$urandom}}});
      iq = if_drv;
      lq = ls_drv;
      run_traffic(c0, 2000);
      // Transaction-level model: one transaction at a time, write occupies
      // 2 cycles, read RD+2 cycles, load/store preferred until streak limit.
      exp_q.delete();
      t = c0 + 1;
      streak = 0;
      while (iq.size() > 0 || lq.size() > 0) begin
         if (iq.size() > 0 && (lq.size() == 0 || streak == SM)) begin
            a = iq.pop_front();
            exp_q.push_back(mk_ev(t, 2'd0, 1'b0, 1'b0, 1'b1, a, '0));
            exp_q.push_back(mk_ev(t + RD + 1, 2'd1, 1'b0, 1'b0, 1'b0, '0,
                                  mm.exists(a) ? mm[a] : pat(a)));
            streak = 0;
            t += RD + 2;
         end else begin
            e = lq.pop_front();
            a = e[AW+DW-1:DW];
            streak = (iq.size() > 0) ? streak + 1 : 0;
            if (e[AW+DW]) begin
               mm[a] = e[DW-1:0];
               exp_q.push_back(mk_ev(t, 2'd0, 1'b1, 1'b1, 1'b0, a, e[DW-1:0]));
               t += 2;
            end else begin
               exp_q.push_back(mk_ev(t, 2'd0, 1'b1, 1'b0, 1'b1, a, '0));
               exp_q.push_back(mk_ev(t + RD + 1, 2'd1, 1'b1, 1'b0, 1'b0, '0,
                                     mm.exists(a) ? mm[a] : pat(a)));
               t += RD + 2;
            end
         end
      end
      n_checks++;
      if (act_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL rand%0d_event_count: got %0d, required %0d", iter, act_q.size(),
                  exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rand%0d_event%0d: got %h, required %h", iter, i,
                     (i < act_q.size()) ? act_q[i] : '0, exp_q[i]);
         end
      end
   endtask

   // ---------------- main sequence + report ----------------
   initial begin
      bus.if_req = 1'b0;  bus.if_addr = '0;
      bus.ls_req = 1'b0;  bus.ls_we = 1'b0;  bus.ls_addr = '0;  bus.ls_wdata = '0;
      bus.mem_rdata = '0;
      bus1.if_req = 1'b0; bus1.if_addr = '0;
      bus1.ls_req = 1'b0; bus1.ls_we = 1'b0; bus1.ls_addr = '0; bus1.ls_wdata = '0;
      bus1.mem_rdata = '0;

      test_reset();
      test_load_read();
      test_store();
      test_fairness();
      test_reset_in_wait();
      test_back_to_back();
      for (int it = 0; it < 4; it++) test_random(it);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before the end of the sequence");
      $fatal(1, "watchdog");
   end

endmodule : tb_mem_port_arbiter
